alu_cmp_sequencer: RTL and testbench
====================================

// Module: alu_cmp_sequencer
// PURPOSE
//  Multi-cycle unsigned magnitude comparator controller for the ALU. Sequences one
//  6-bit slice compare per cycle, MSB slice first, over a WIDTH = 6*NSLICE operand
//  pair. Reports A>=B and A==B through valid/ready handshakes on input and output.
//  Lets wide compares reuse the 6-bit greater-than/equal slice logic.
// PARAMETERS
//  NSLICE      4   number of 6-bit slices; WIDTH = 6*NSLICE; legal range 1..8
//  EARLY_EXIT  1   1: stop at the first unequal slice; 0: always scan all NSLICE slices
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept; high only in IDLE and with rst low
//  a          in   WIDTH  operand A, unsigned
//  b          in   WIDTH  operand B, unsigned
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  gte        out  1      A >= B
//  eq         out  1      A == B
//  cycles     out  4      number of slices examined, 1..NSLICE
//  busy       out  1      high in CMP and DONE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; out_valid=0, gte=0, eq=0, cycles=0, busy=0.
//   in_ready=0 while rst is high. The operand registers and the slice index clear to 0.
//  FSM states are IDLE, CMP and DONE.
//   IDLE: in_ready=1. On in_valid&in_ready at edge E0:
//    - latch a and b;
//    - idx=NSLICE-1, decided=0, cycles=0;
//    - go to CMP.
//   CMP: each cycle compare slice idx, bits [6*idx+5:6*idx] of the latched A and B.
//    - cycles increments by 1 per slice compared.
//    - First unequal slice (decided=0): record gt=(A_s>B_s) and set decided=1.
//    - EARLY_EXIT=1: go to DONE at once, with gte=gt and eq=0.
//    - EARLY_EXIT=0: keep scanning. Later slices never change the recorded result.
//    - At idx==0 go to DONE:
//      - decided=0: gte=1, eq=1;
//      - decided=1: gte=gt, eq=0.
//    - Otherwise idx decrements.
//   DONE: out_valid=1. gte, eq and cycles stay stable until out_valid&out_ready,
//    then go to IDLE.
//  Latency: out_valid rises after edge E_k, where k=cycles.
//   - EARLY_EXIT=1: k = 1 + number of equal leading slices (at most NSLICE).
//   - EARLY_EXIT=0: k = NSLICE.
//  Throughput: one operation per k+2 cycles at most. No accept in the same cycle as
//   the output handshake; the next operation is accepted from IDLE on the cycle after.
//  in_valid is ignored outside IDLE. The a/b inputs may change freely after the accept.
//  out_ready is ignored when out_valid=0.
//  gte, eq and cycles keep their last values in IDLE until the next DONE.
//  They are meaningful only while out_valid=1.
//  NSLICE=1: always k=1.
//  Reset during CMP or DONE aborts the operation: no out_valid, result discarded.
//  All state is in registers. The slice compare is combinational on the latched
//   operands, never on the a/b ports.
// TESTING
//  NSLICE=4, EARLY_EXIT=1 unless noted.
//  1) a=0x000041, b=0x000040 -> k=4: out_valid after E4, gte=1, eq=0, cycles=4.
//  2) a=0xFC0000, b=0x000000 -> gte=1, eq=0, cycles=1, out_valid after E1.
//     With EARLY_EXIT=0 -> same result, cycles=4.
//  3) a=b=0x123456 -> gte=1, eq=1, cycles=4. Also a=b=0 -> gte=1, eq=1.
//  4) a=0x03FFFF, b=0x040000 -> gte=0, eq=0, cycles=1.
//     a=0xFFFFFE, b=0xFFFFFF -> gte=0, cycles=4.
//  5) Hold out_ready=0 for 5 cycles with in_valid=1 and new operands ->
//     out_valid, gte, eq, cycles stable; in_ready=0; no second op accepted.
//     Release -> IDLE; the next op is accepted the following cycle.
//  6) Assert rst mid-CMP (after E2 of case 1) -> out_valid=0 immediately; in_ready=1
//     after release; a following case 3 compare returns eq=1, cycles=4.

Source files
------------

// File: rtl/alu_cmp_sequencer_if.sv
// Handshake bundle for the sliced magnitude comparator: operand channel in, result channel out.
`default_nettype none

interface alu_cmp_sequencer_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gte;
  logic             eq;
  logic [3:0]       cycles;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gte, eq, cycles, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gte, eq, cycles, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_cmp_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_cmp_sequencer                                                          |
// | Multi-cycle unsigned A>=B / A==B compare, one 6-bit slice per cycle, MSB   |
// | slice first, with valid/ready handshakes on operands and result.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_cmp_sequencer #(
  parameter int NSLICE     = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  alu_cmp_sequencer_if.slave  bus
);

  localparam int         c_width    = 6 * NSLICE;
  localparam logic [2:0] c_last_idx = 3'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_width-1:0] r_a, w_a_next;
  logic [c_width-1:0] r_b, w_b_next;
  logic [2:0]         r_idx, w_idx_next;
  logic               r_decided, w_decided_next;
  logic               r_gt, w_gt_next;
  logic [3:0]         r_cnt, w_cnt_next;
  logic               r_gte, w_gte_next;
  logic               r_eq, w_eq_next;
  logic [3:0]         r_cycles, w_cycles_next;

  logic [c_width-1:0] w_a_sh, w_b_sh;
  logic [5:0]         w_a_s, w_b_s;
  logic               w_slice_ne, w_slice_gt;
  logic               w_dec_now, w_gt_now;

  // Slice select works on the latched operands only; the ports may already carry the next op.
  assign w_a_sh     = r_a >> (6 * r_idx);
  assign w_b_sh     = r_b >> (6 * r_idx);
  assign w_a_s      = w_a_sh[5:0];
  assign w_b_s      = w_b_sh[5:0];
  assign w_slice_ne = (w_a_s != w_b_s);
  assign w_slice_gt = (w_a_s > w_b_s);
  assign w_dec_now  = r_decided | w_slice_ne;
  assign w_gt_now   = r_decided ? r_gt : w_slice_gt;

  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_b_next       = r_b;
    w_idx_next     = r_idx;
    w_decided_next = r_decided;
    w_gt_next      = r_gt;
    w_cnt_next     = r_cnt;
    w_gte_next     = r_gte;
    w_eq_next      = r_eq;
    w_cycles_next  = r_cycles;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_a_next       = bus.a;
          w_b_next       = bus.b;
          w_idx_next     = c_last_idx;
          w_decided_next = 1'b0;
          w_cnt_next     = 4'd0;
          w_state_next   = ST_CMP;
        end
      end
      ST_CMP: begin
        w_cnt_next = r_cnt + 4'd1;
        // Only the first unequal slice sets the verdict; later slices are scanned but ignored.
        if (!r_decided && w_slice_ne) begin
          w_decided_next = 1'b1;
          w_gt_next      = w_slice_gt;
        end
        if ((EARLY_EXIT && w_slice_ne && !r_decided) || (r_idx == 3'd0)) begin
          w_state_next  = ST_DONE;
          w_gte_next    = w_dec_now ? w_gt_now : 1'b1;
          w_eq_next     = ~w_dec_now;
          w_cycles_next = r_cnt + 4'd1;
        end else begin
          w_idx_next = r_idx - 3'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= 3'd0;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_cnt     <= 4'd0;
      r_gte     <= 1'b0;
      r_eq      <= 1'b0;
      r_cycles  <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_idx     <= w_idx_next;
      r_decided <= w_decided_next;
      r_gt      <= w_gt_next;
      r_cnt     <= w_cnt_next;
      r_gte     <= w_gte_next;
      r_eq      <= w_eq_next;
      r_cycles  <= w_cycles_next;
    end
  end

  // in_ready is gated by rst directly so it drops the instant reset is asserted.
  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.gte       = r_gte;
  assign bus.eq        = r_eq;
  assign bus.cycles    = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmp_sequencer.sv
// Scoreboard bench for alu_cmp_sequencer: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance, NSLICE=4.
`default_nettype none

module tb_alu_cmp_sequencer;

  typedef struct {
    logic       gte;
    logic       eq;
    logic [3:0] cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel = 1'b0;
  logic        tb_valid = 1'b0;
  logic        tb_rdy = 1'b0;
  logic [23:0] tb_a = '0;
  logic [23:0] tb_b = '0;

  int n_pass  = 0;
  int n_total = 0;
  exp_t sb[$];

  alu_cmp_sequencer_if #(.WIDTH(24)) if_e ();
  alu_cmp_sequencer_if #(.WIDTH(24)) if_f ();

  assign if_e.in_valid  = tb_valid & ~sel;
  assign if_f.in_valid  = tb_valid & sel;
  assign if_e.out_ready = tb_rdy & ~sel;
  assign if_f.out_ready = tb_rdy & sel;
  assign if_e.a = tb_a;
  assign if_e.b = tb_b;
  assign if_f.a = tb_a;
  assign if_f.b = tb_b;

  logic       obs_in_ready, obs_out_valid, obs_gte, obs_eq, obs_busy;
  logic [3:0] obs_cycles;
  assign obs_in_ready  = sel ? if_f.in_ready  : if_e.in_ready;
  assign obs_out_valid = sel ? if_f.out_valid : if_e.out_valid;
  assign obs_gte       = sel ? if_f.gte       : if_e.gte;
  assign obs_eq        = sel ? if_f.eq        : if_e.eq;
  assign obs_busy      = sel ? if_f.busy      : if_e.busy;
  assign obs_cycles    = sel ? if_f.cycles    : if_e.cycles;

  alu_cmp_sequencer #(.NSLICE(4), .EARLY_EXIT(1'b1)) u_dut_early (
    .clk (clk),
    .rst (rst),
    .bus (if_e)
  );

  alu_cmp_sequencer #(.NSLICE(4), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk (clk),
    .rst (rst),
    .bus (if_f)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input bit full);
    exp_t e;
    int   k;
    bit   run;
    e.gte = (a >= b);
    e.eq  = (a == b);
    k     = 1;
    run   = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (run && (a[6*i +: 6] == b[6*i +: 6])) k++;
      else run = 1'b0;
    end
    e.cycles = full ? 4'd4 : 4'(k);
    return e;
  endfunction

  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input bit full);
    int n;
    @(negedge clk);
    sel      = full;
    tb_a     = a;
    tb_b     = b;
    tb_valid = 1'b1;
    sb.push_back(model(a, b, full));
    n = 0;
    while (!obs_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    tb_a     = 24'($urandom);
    tb_b     = 24'($urandom);
    n_total++;
    if (n >= 20 || obs_busy !== 1'b1 || obs_in_ready !== 1'b0)
      $display("FAIL accept: wait=%0d busy=%b in_ready=%b, required accept with busy=1 in_ready=0",
               n, obs_busy, obs_in_ready);
    else n_pass++;
  endtask

  task automatic finish_op(input int hold);
    int   k;
    exp_t e;
    k = 0;
    while (!obs_out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: out_valid=%b with no pending op", obs_out_valid);
      return;
    end
    e = sb.pop_front();
    if (obs_out_valid !== 1'b1 || k !== int'(e.cycles))
      $display("FAIL latency: out_valid=%b after %0d edges, required 1 after %0d", obs_out_valid, k, e.cycles);
    else n_pass++;
    n_total++;
    if ({obs_gte, obs_eq, obs_cycles} !== {e.gte, e.eq, e.cycles})
      $display("FAIL result: gte=%b eq=%b cycles=%0d, required gte=%b eq=%b cycles=%0d",
               obs_gte, obs_eq, obs_cycles, e.gte, e.eq, e.cycles);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if ({obs_out_valid, obs_in_ready, obs_gte, obs_eq, obs_cycles} !== {1'b1, 1'b0, e.gte, e.eq, e.cycles})
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b gte=%b eq=%b cycles=%0d, required 1 0 %b %b %0d",
                 i, obs_out_valid, obs_in_ready, obs_gte, obs_eq, obs_cycles, e.gte, e.eq, e.cycles);
      else n_pass++;
    end
    tb_rdy = 1'b1;
    @(posedge clk);
    #1;
    tb_rdy = 1'b0;
    n_total++;
    if ({obs_out_valid, obs_in_ready, obs_busy} !== 3'b010)
      $display("FAIL release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               obs_out_valid, obs_in_ready, obs_busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({if_e.in_ready, if_e.out_valid, if_f.in_ready, if_f.out_valid} !== 4'b0000)
      $display("FAIL reset_hold: in_ready=%b/%b out_valid=%b/%b, required all 0",
               if_e.in_ready, if_f.in_ready, if_e.out_valid, if_f.out_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if ({if_e.in_ready, if_e.busy, if_e.gte, if_e.eq, if_e.cycles, if_f.in_ready, if_f.busy} !== {3'b100, 1'b0, 4'd0, 2'b10})
      $display("FAIL reset_state: in_ready=%b busy=%b gte=%b eq=%b cycles=%0d f.in_ready=%b f.busy=%b, required 1 0 0 0 0 1 0",
               if_e.in_ready, if_e.busy, if_e.gte, if_e.eq, if_e.cycles, if_f.in_ready, if_f.busy);
    else n_pass++;
  endtask

  task automatic test_directed;
    start_op(24'h000041, 24'h000040, 1'b0); finish_op(0);
    start_op(24'hFC0000, 24'h000000, 1'b0); finish_op(0);
    start_op(24'hFC0000, 24'h000000, 1'b1); finish_op(0);
    start_op(24'h123456, 24'h123456, 1'b0); finish_op(0);
    start_op(24'h000000, 24'h000000, 1'b0); finish_op(0);
    start_op(24'h03FFFF, 24'h040000, 1'b0); finish_op(0);
    start_op(24'hFFFFFE, 24'hFFFFFF, 1'b0); finish_op(0);
    start_op(24'h03FFFF, 24'h040000, 1'b1); finish_op(0);
    start_op(24'h000041, 24'h000040, 1'b1); finish_op(0);
  endtask

  task automatic test_backpressure;
    start_op(24'h000041, 24'h000040, 1'b0);
    // New operands sit on the bus throughout CMP and DONE and must not be taken early.
    tb_valid = 1'b1;
    tb_a     = 24'h123456;
    tb_b     = 24'h123456;
    finish_op(5);
    @(posedge clk);
    #1;
    n_total++;
    if ({obs_busy, obs_in_ready} !== 2'b10)
      $display("FAIL next_accept: busy=%b in_ready=%b, required 1 0", obs_busy, obs_in_ready);
    else n_pass++;
    tb_valid = 1'b0;
    sb.push_back(model(24'h123456, 24'h123456, 1'b0));
    finish_op(0);
  endtask

  task automatic test_reset_mid;
    bit seen;
    start_op(24'h000041, 24'h000040, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_total++;
    if ({obs_out_valid, obs_busy, obs_in_ready, obs_gte, obs_eq, obs_cycles} !== {5'b00000, 4'd0})
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b gte=%b eq=%b cycles=%0d, required all 0",
               obs_out_valid, obs_busy, obs_in_ready, obs_gte, obs_eq, obs_cycles);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL post_reset_idle: stray out_valid or in_ready low, required idle");
    else n_pass++;
    start_op(24'h123456, 24'h123456, 1'b0);
    finish_op(0);
  endtask

  task automatic test_back_to_back;
    logic [23:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 24'($urandom);
      b = a ^ (24'd1 << $urandom_range(0, 23));
      if (i % 3 == 0) b = a;
      if (i % 4 == 1) b = 24'($urandom);
      start_op(a, b, (i % 2) == 1);
      finish_op(i % 3);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
